shift_seq: RTL and testbench

Multi-cycle shift/rotate sequencer that sits directly upstream of the ALU result (Z) register and replaces the purely combinational shift/rotate path for shifts by a register count. It accepts an opcode, a 32-bit operand and a shift count over a valid/ready handshake. It then performs one single-bit step per clock and presents the result to the Z-register loader over a second valid/ready handshake. It covers logical left/right shift, arithmetic right shift, and left/right rotate.

---
 rtl/shift_pkg.sv | 37 +++
 rtl/shift_step.sv | 24 ++
 rtl/shift_seq.sv | 80 ++++++++
 tb/tb_shift_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared opcode/state types and effective-count rule for the shift/rotate sequencer.
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_SHL  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHRA = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

  // Shifts saturate at WIDTH steps; rotates wrap modulo WIDTH; illegal ops take no steps.
  function automatic logic [CNT_W:0] eff_count(input logic [2:0] op, input logic [WIDTH-1:0] count);
    logic [CNT_W:0] n;
    n = '0;
    case (op)
      OP_SHL, OP_SHR, OP_SHRA: n = (count >= WIDTH) ? (CNT_W+1)'(WIDTH) : {1'b0, count[CNT_W-1:0]};
      OP_ROL, OP_ROR:          n = {1'b0, count[CNT_W-1:0]};
      default:                 n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step of the working register.
// Combinational, no handshake.
module shift_step #(
  parameter int WIDTH = shift_pkg::WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] w_nxt
);
  import shift_pkg::*;

  always_comb begin
    w_nxt = w;
    case (op)
      OP_SHL:  w_nxt = {w[WIDTH-2:0], 1'b0};
      OP_SHR:  w_nxt = {1'b0, w[WIDTH-1:1]};
      OP_SHRA: w_nxt = {w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROL:  w_nxt = {w[WIDTH-2:0], w[WIDTH-1]};
      OP_ROR:  w_nxt = {w[0], w[WIDTH-1:1]};
      default: w_nxt = w;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer feeding the Z-register loader, one bit per clock.
// Latency n+1 cycles from accept; holds result in DONE until out_ready, no overlap of requests.
module shift_seq #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int CNT_W = shift_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);
  import shift_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_step;
  logic [2:0]       op_q;
  logic [CNT_W:0]   rem_q;
  logic [CNT_W:0]   n_in;
  logic             err_q;

  assign n_in = eff_count(op, count);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .w     (w_q),
    .w_nxt (w_step)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (n_in == '0) ? DONE : RUN;
      RUN:  if (rem_q == (CNT_W+1)'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      w_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          w_q   <= operand;
          op_q  <= op;
          rem_q <= n_in;
          err_q <= !op_legal(op);
        end
        RUN: begin
          w_q   <= w_step;
          rem_q <= rem_q - (CNT_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs depend on registered state only (clr gates in_ready during reset).
  assign in_ready  = (state_q == IDLE) && clr;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = w_q;
  assign err       = err_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed vector bench for shift_seq: result, err, latency, handshakes, reset and back-pressure.
module tb_shift_seq;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] operand;
  logic [31:0] count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;
  logic        busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] operand;
    logic [31:0] count;
    logic [31:0] exp_result;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  shift_seq dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure edges from accept to out_valid, check and drain.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] c,
                        input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
    int edges;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; operand = a; count = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      step();
      edges++;
    end
    check("latency", 32'(edges), 32'(exp_lat));
    check("result", result, exp_res);
    check("err", 32'(err), 32'(exp_err));
    check("in_ready_done", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0001, 32'd4,          32'h0000_0010, 1'b0, 4};
    vecs[1]  = '{3'b010, 32'h8000_0000, 32'd40,         32'hFFFF_FFFF, 1'b0, 32};
    vecs[2]  = '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 32};
    vecs[3]  = '{3'b100, 32'h0000_0001, 32'd1,          32'h8000_0000, 1'b0, 1};
    vecs[4]  = '{3'b011, 32'h8000_0001, 32'd36,         32'h0000_0018, 1'b0, 4};
    vecs[5]  = '{3'b000, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 1'b0, 0};
    vecs[6]  = '{3'b111, 32'hDEAD_BEEF, 32'd5,          32'hDEAD_BEEF, 1'b1, 0};
    vecs[7]  = '{3'b010, 32'h7000_0000, 32'd3,          32'h0E00_0000, 1'b0, 3};
    vecs[8]  = '{3'b010, 32'hF000_000F, 32'd4,          32'hFF00_0000, 1'b0, 4};
    vecs[9]  = '{3'b011, 32'h1234_5678, 32'd32,         32'h1234_5678, 1'b0, 0};
    vecs[10] = '{3'b000, 32'hFFFF_FFFF, 32'd31,         32'h8000_0000, 1'b0, 31};
    vecs[11] = '{3'b001, 32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 1'b0, 32};
    vecs[12] = '{3'b100, 32'h1234_5678, 32'd8,          32'h7812_3456, 1'b0, 8};
    vecs[13] = '{3'b101, 32'h0000_00A5, 32'd3,          32'h0000_00A5, 1'b1, 0};

    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; operand = '0; count = '0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    clr = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    step();

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].operand, vecs[i].count,
             vecs[i].exp_result, vecs[i].exp_err, vecs[i].exp_lat);

    // Back-pressure: hold DONE, pulse in_valid with a different request.
    begin
      int edges;
      op = 3'b000; operand = 32'h3; count = 32'd2; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      edges = 0;
      while (!out_valid && edges < 40) begin step(); edges++; end
      check("bp_latency", 32'(edges), 32'd2);
      for (int k = 0; k < 10; k++) begin
        op = 3'b001; operand = 32'hFFFF_0000; count = 32'd1;
        in_valid = k[0];
        step();
        check("bp_result", result, 32'h0000_000C);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      step();
      check("bp_no_capture", 32'(busy), 32'd0);
    end

    // Reset in the middle of a long rotate.
    op = 3'b011; operand = 32'h1; count = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("midrun_busy", 32'(busy), 32'd1);
    clr = 1'b0;
    step();
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_result", result, 32'd0);
    clr = 1'b1;
    step();
    run_op(3'b000, 32'h1, 32'd1, 32'h2, 1'b0, 1);

    // Reset wins over a request at the same edge.
    clr = 1'b0; op = 3'b000; operand = 32'h55; count = 32'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b1;
    #1;
    check("rst_vs_req_busy", 32'(busy), 32'd0);
    check("rst_vs_req_result", result, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
